// File: rtl/regfile_wb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_wb: 32x DATA_W register file, 2 comb read ports, 1 write port |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [4:0]        raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count,
    output logic [4:0]        last_waddr
);

    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        last_q, last_d;
    logic              w_commit;

    // A write to r0 is not a committed write: no storage, counter or index update.
    assign w_commit = we && (waddr != 5'd0);

    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if (w_commit) begin
            regs_d[waddr] = wdata;
            cnt_d         = cnt_q + CNT_W'(1);
            last_d        = waddr;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    always_comb begin
        rdata1 = regs_q[raddr1];
        if (raddr1 == 5'd0)
            rdata1 = '0;
        else if ((BYPASS != 0) && w_commit && (raddr1 == waddr))
            rdata1 = wdata;
    end

    always_comb begin
        rdata2 = regs_q[raddr2];
        if (raddr2 == 5'd0)
            rdata2 = '0;
        else if ((BYPASS != 0) && w_commit && (raddr2 == waddr))
            rdata2 = wdata;
    end

    assign dbg_data   = regs_q[dbg_addr];
    assign wr_count   = cnt_q;
    assign last_waddr = last_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb.sv
`default_nettype none
// Two instances share stimulus: bypassing/16-bit counter and stored-read/4-bit counter.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst_n, we;
    logic [4:0]  waddr, raddr1, raddr2, dbg_addr;
    logic [31:0] wdata;
    logic [31:0] a_r1, a_r2, a_dbg, b_r1, b_r2, b_dbg;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;
    logic [4:0]  a_last, b_last;

    always #5 clk = ~clk;

    regfile_wb #(.DATA_W(32), .BYPASS(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(a_r1), .raddr2(raddr2), .rdata2(a_r2),
        .dbg_addr(dbg_addr), .dbg_data(a_dbg), .wr_count(a_cnt), .last_waddr(a_last)
    );

    regfile_wb #(.DATA_W(32), .BYPASS(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(b_r1), .raddr2(raddr2), .rdata2(b_r2),
        .dbg_addr(dbg_addr), .dbg_data(b_dbg), .wr_count(b_cnt), .last_waddr(b_last)
    );

    typedef struct {
        logic [31:0] a_r1, a_r2, b_r1, b_r2, dbg;
        logic [15:0] a_cnt;
        logic [3:0]  b_cnt;
        logic [4:0]  last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [32];
    int unsigned mdl_cnt;
    logic [4:0]  mdl_last;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0)
            return 32'd0;
        if (byp && we && waddr != 5'd0 && a == waddr)
            return wdata;
        return mdl[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mdl_cnt  = 0;
        mdl_last = 5'd0;
    endtask

    // Drive one cycle of inputs, queue the expected observation, then advance the model.
    task automatic step(input logic rn, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] da);
        exp_t e;
        rst_n = rn; we = w; waddr = wa; wdata = wd;
        raddr1 = a1; raddr2 = a2; dbg_addr = da;
        e.a_r1  = exp_rd(a1, 1'b1);
        e.a_r2  = exp_rd(a2, 1'b1);
        e.b_r1  = exp_rd(a1, 1'b0);
        e.b_r2  = exp_rd(a2, 1'b0);
        e.dbg   = mdl[da];
        e.a_cnt = 16'(mdl_cnt % 65536);
        e.b_cnt = 4'(mdl_cnt % 16);
        e.last  = mdl_last;
        sb.push_back(e);
        @(posedge clk);
        if (!rn)
            model_clear();
        else if (w && wa != 5'd0) begin
            mdl[wa]  = wd;
            mdl_cnt  = mdl_cnt + 1;
            mdl_last = wa;
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("a_rdata1",   a_r1,          e.a_r1);
                chk("a_rdata2",   a_r2,          e.a_r2);
                chk("b_rdata1",   b_r1,          e.b_r1);
                chk("b_rdata2",   b_r2,          e.b_r2);
                chk("a_dbg_data", a_dbg,         e.dbg);
                chk("b_dbg_data", b_dbg,         e.dbg);
                chk("a_wr_count", 32'(a_cnt),    32'(e.a_cnt));
                chk("b_wr_count", 32'(b_cnt),    32'(e.b_cnt));
                chk("a_last",     32'(a_last),   32'(e.last));
                chk("b_last",     32'(b_last),   32'(e.last));
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();

        // Reset clear with a simultaneous write
        step(1, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5);
        step(1, 0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        step(0, 1, 5'd5, 32'h1234, 5'd5, 5'd0, 5'd5);
        step(1, 0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);

        // Basic write/read
        step(1, 1, 5'd8, 32'h0000_00AA, 5'd8, 5'd31, 5'd8);
        step(1, 1, 5'd31, 32'hFFFF_FFFF, 5'd8, 5'd31, 5'd31);
        step(1, 0, 5'd0, 32'h0, 5'd8, 5'd31, 5'd31);

        // Register 0 immunity
        step(1, 1, 5'd0, 32'h5555_5555, 5'd0, 5'd0, 5'd0);
        step(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

        // Bypass versus stored read
        step(1, 1, 5'd9, 32'h10, 5'd0, 5'd0, 5'd9);
        step(1, 1, 5'd9, 32'h20, 5'd9, 5'd9, 5'd9);
        step(1, 0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);

        // Counter wrap on the 4-bit instance
        step(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 17; i++)
            step(1, 1, 5'd1, 32'(100 + i), 5'd1, 5'd1, 5'd1);
        step(1, 0, 5'd0, 32'h0, 5'd1, 5'd1, 5'd1);

        // Mid-run reset
        for (int r = 2; r <= 6; r++)
            step(1, 1, 5'(r), 32'(r * 16 + 3), 5'(r), 5'd2, 5'(r));
        step(0, 0, 5'd0, 32'h0, 5'd2, 5'd6, 5'd4);
        step(1, 1, 5'd3, 32'h77, 5'd3, 5'd2, 5'd3);
        step(1, 0, 5'd0, 32'h0, 5'd2, 5'd4, 5'd5);
        step(1, 0, 5'd0, 32'h0, 5'd6, 5'd3, 5'd3);

        // Random traffic, addresses concentrated so bypass and reuse occur often
        for (int i = 0; i < 400; i++) begin
            logic [4:0] wa;
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            step(($urandom_range(0, 40) != 0), 1'($urandom_range(0, 1)), wa, $urandom(),
                 ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 5)),
                 ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 5)));
        end

        repeat (3) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS datapath.
- Sink end of the destination-register select path. The 5-bit write address comes from the rt/rd destination select, and write data comes from the write-back select.
- Provides two combinational read ports (rs, rt) to the decode/ALU stage and one synchronous write port.
- Provides a debug read port and a retired-write counter for bench observation.

Parameters:
- DATA_W, 32, register width in bits.
- BYPASS, 1, when 1, a read whose address equals the in-flight write address returns write data in the same cycle (write-through forwarding); when 0, a read returns the stored value.
- CNT_W, 16, width of the retired-write counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- we  input  1  write enable (RegWrite).
- waddr  input  5  write register index (output of destination select).
- wdata  input  DATA_W  write-back data.
- raddr1  input  5  read port 1 index (rs).
- rdata1  output  DATA_W  read port 1 data.
- raddr2  input  5  read port 2 index (rt).
- rdata2  output  DATA_W  read port 2 data.
- dbg_addr  input  5  debug read index.
- dbg_data  output  DATA_W  debug read data; always the stored value, never bypassed.
- wr_count  output  CNT_W  number of committed writes since reset.
- last_waddr  output  5  index of the most recent committed write.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n. No asynchronous reset path exists.
- Reset (rst_n=0 at a rising edge):
  - All 32 registers clear to 0.
  - wr_count clears to 0.
  - last_waddr clears to 0.
  - Reset overrides a simultaneous we=1; the write is discarded.
  - Reset asserted mid-program takes effect at the next edge regardless of other inputs.
- Write:
  - At a rising edge with rst_n=1, we=1 and waddr!=0: reg[waddr] <= wdata, wr_count increments, last_waddr <= waddr.
  - Write latency is 1 cycle: the value is stored and visible to dbg_data after the edge.
- Register 0:
  - Hardwired to 0 and never written.
  - we=1 with waddr=0 is not a committed write: wr_count and last_waddr are unchanged.
- we=0: no state change.
- Read ports: combinational, zero latency.
  - rdataN = 0 when raddrN=0, regardless of bypass.
  - If BYPASS=1, we=1, waddr!=0 and raddrN==waddr: rdataN = wdata.
  - Otherwise rdataN = reg[raddrN].
  - Both ports may address the same register; each resolves independently.
- Counter: wr_count wraps from 2^CNT_W−1 to 0 with no saturation and no flag.
- Unknown inputs: an X on we while rst_n=1 is a bench error. The design makes no X-tolerance guarantee beyond standard simulation semantics.
- No internal state machine beyond the storage array and counter. All updates occur only at rising clk edges.

Test Plan:
- Reset clear: preload reg[5]=0xDEADBEEF, then hold rst_n=0 for 1 edge with we=1, waddr=5, wdata=0x1234 -> after the edge, dbg_data(5)=0, wr_count=0, last_waddr=0.
- Basic write/read: write 0x0000_00AA to r8, then r31=0xFFFF_FFFF on consecutive edges; set raddr1=8, raddr2=31 -> rdata1=0xAA, rdata2=0xFFFFFFFF, wr_count=2, last_waddr=31.
- Register 0 immunity: we=1, waddr=0, wdata=0x5555_5555 -> rdata1(raddr1=0)=0 both before and after the edge, wr_count unchanged.
- Bypass: BYPASS=1, r9=0x10 stored; drive we=1, waddr=9, wdata=0x20, raddr1=raddr2=9 -> rdata1=rdata2=0x20 before the edge while dbg_data(9)=0x10; after the edge, dbg_data=0x20. Repeat with BYPASS=0 -> reads show 0x10 before the edge.
- Counter wrap: CNT_W=4; perform 17 writes to r1 with incrementing data -> wr_count sequence ends at 1, last_waddr=1, r1 = final data.
- Mid-run reset: after 5 writes to r2..r6, assert rst_n=0 for one edge, then release and write r3=0x77 -> r2, r4, r5, r6 read 0, r3=0x77, wr_count=1.
